// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared types and constants for the data memory arbiter
package data_memory_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int         MEM_BYTES_DEFAULT = 32;
  localparam logic [1:0] ALIGN_MASK        = 2'b11;

  // The range test is kept at full 32-bit width so high address bits can't alias into memory.
  function automatic logic addr_err(input logic [31:0] addr, input int mem_bytes);
    return ((addr[1:0] & ALIGN_MASK) != 2'b00) || (addr > 32'(mem_bytes - 4));
  endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// rtl/data_memory_arbiter_if.sv - two requester ports plus the memory-side bus
interface data_memory_arbiter_if;

  logic        p0_req_i;
  logic        p0_we_i;
  logic [31:0] p0_addr_i;
  logic [31:0] p0_wdata_i;
  logic        p0_ack_o;
  logic [31:0] p0_rdata_o;

  logic        p1_req_i;
  logic        p1_we_i;
  logic [31:0] p1_addr_i;
  logic [31:0] p1_wdata_i;
  logic        p1_ack_o;
  logic [31:0] p1_rdata_o;

  logic        err_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_write_o;
  logic        mem_read_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
    input  p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
    input  mem_rdata_i,
    output p0_ack_o, p0_rdata_o, p1_ack_o, p1_rdata_o,
    output err_o, mem_addr_o, mem_wdata_o, mem_write_o, mem_read_o
  );

  modport master (
    output p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
    output p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
    output mem_rdata_i,
    input  p0_ack_o, p0_rdata_o, p1_ack_o, p1_rdata_o,
    input  err_o, mem_addr_o, mem_wdata_o, mem_write_o, mem_read_o
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin arbiter, one-hot grant
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) begin
      // On a tie the port not granted last time wins.
      o_gnt = i_last_grant ? 2'b01 : 2'b10;
    end else begin
      o_gnt = i_req;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - two-port round-robin sequencer in front of the data memory
module data_memory_arbiter
  import data_memory_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  data_memory_arbiter_if.slave bus
);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last_grant;
  logic        r_winner;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [1:0]  w_req;
  logic [1:0]  w_gnt;
  logic        w_sel;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;

  assign w_req = {bus.p1_req_i, bus.p0_req_i};

  rr_arbiter2 u_rr_arbiter2 (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_gnt)
  );

  assign w_sel       = w_gnt[1];
  assign w_sel_we    = w_sel ? bus.p1_we_i    : bus.p0_we_i;
  assign w_sel_addr  = w_sel ? bus.p1_addr_i  : bus.p0_addr_i;
  assign w_sel_wdata = w_sel ? bus.p1_wdata_i : bus.p0_wdata_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = (w_req != 2'b00) ? ACCESS : IDLE;
      ACCESS:  w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_last_grant <= 1'b1;
      r_winner     <= 1'b0;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_rdata      <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req != 2'b00) begin
            r_winner <= w_sel;
            r_we     <= w_sel_we;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_err    <= addr_err(w_sel_addr, MEM_BYTES);
          end
        end
        ACCESS: begin
          r_rdata <= (!r_we && !r_err) ? bus.mem_rdata_i : 32'd0;
        end
        RESP: begin
          r_last_grant <= r_winner;
        end
        default: ;
      endcase
    end
  end

  // Write strobe is gated by reset so an access aborted mid-ACCESS never commits.
  always_comb begin
    bus.p0_ack_o    = 1'b0;
    bus.p0_rdata_o  = 32'd0;
    bus.p1_ack_o    = 1'b0;
    bus.p1_rdata_o  = 32'd0;
    bus.err_o       = 1'b0;
    bus.mem_addr_o  = 32'd0;
    bus.mem_wdata_o = 32'd0;
    bus.mem_write_o = 1'b0;
    bus.mem_read_o  = 1'b0;
    case (r_state)
      ACCESS: begin
        bus.mem_addr_o  = r_addr;
        bus.mem_wdata_o = r_wdata;
        bus.mem_write_o = r_we & ~r_err & rst_i;
        bus.mem_read_o  = ~r_we & ~r_err;
      end
      RESP: begin
        bus.err_o = r_err;
        if (r_winner) begin
          bus.p1_ack_o   = 1'b1;
          bus.p1_rdata_o = r_rdata;
        end else begin
          bus.p0_ack_o   = 1'b1;
          bus.p0_rdata_o = r_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter and sequencer in front of the byte-addressed 32-byte data memory. Port 0 serves the CPU MEM stage; port 1 serves the debug/loader path. The block arbitrates round-robin between the two ports and drives the memory's address, write-data and read/write strobes for one word access at a time. Each access returns a registered read word (or write acknowledge) with an error flag for misaligned or out-of-range addresses.

## Interface
- MEM_BYTES, 32: memory size in bytes; legal word addresses are 0..MEM_BYTES-4.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- p0_req_i, p1_req_i  in  1  access request; held high until that port's ack.
- p0_we_i, p1_we_i  in  1  1 = write word, 0 = read word.
- p0_addr_i, p1_addr_i  in  32  byte address.
- p0_wdata_i, p1_wdata_i  in  32  write word, little-endian byte order.
- p0_ack_o, p1_ack_o  out  1  one-cycle completion pulse.
- p0_rdata_o, p1_rdata_o  out  32  read word; valid while the matching ack is high, otherwise 0.
- err_o  out  1  high with an ack when the completed access was rejected.
- mem_addr_o  out  32  memory address.
- mem_wdata_o  out  32  memory write data.
- mem_write_o, mem_read_o  out  1  memory strobes.
- mem_rdata_i  in  32  combinational memory read word.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: pick a winner, latch its we, addr and wdata plus an error bit, and go to ACCESS.
- Error bit is set when addr[1:0] != 0 or addr > MEM_BYTES-4. The comparison is done at 32 bits, with no truncation.
- Winner selection:
  - Only one port requesting: that port wins.
  - Both ports requesting: the port that was not granted last wins.
  - last_grant resets to 1, so port 0 wins the first tie.
- ACCESS, memory outputs:
  - mem_addr_o and mem_wdata_o come from the latched values.
  - mem_write_o = we & ~err & rst_i.
  - mem_read_o = ~we & ~err.
- ACCESS, capture: on a read, mem_rdata_i is captured into the response register; on a write or an error, 0 is captured. Next state is RESP.
- RESP:
  - The winner's ack_o is high and its rdata_o is driven; err_o shows the latched error bit.
  - last_grant is updated to the winner.
  - Next state is IDLE.
- Requester handshake: the requester must drop req, or present a new request, in the cycle after ack. A req still high in IDLE is treated as a new request.
- Ports are never served concurrently. The losing port's req stays pending and is not acked.
- Request inputs are ignored in ACCESS and RESP. Changes to the winner's inputs after latching have no effect.

## Timing
- Latency: req sampled in IDLE at cycle 0, memory strobes in cycle 1, ack in cycle 2. Throughput is one access every 3 cycles.
- Write commit: memory commits on the rising edge that ends ACCESS. A read-after-write from either port returns the new data.
- Under both ports saturating, grants alternate 0,1,0,1,...
- Outputs and all address/data registers are combinational from state and latched registers; there are no extra output flops.
- Reset values:
  - State IDLE, last_grant 1.
  - All acks, err_o, mem_write_o and mem_read_o are 0.
  - rdata outputs, mem_addr_o and mem_wdata_o are 0.
- Reset mid-operation:
  - rst_i low during ACCESS blocks the write, because mem_write_o is gated by rst_i.
  - rst_i low during RESP: the ack pulse is still visible that cycle, then the next state is IDLE.
  - No ack is issued for an aborted access; the requester re-requests.

## Structure
- Shared package data_memory_pkg holds:
  - The state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2).
  - The MEM_BYTES default.
  - The word-alignment mask (2'b11).
- Sub-module rr_arbiter2:
  - Inputs: req[1:0], last_grant.
  - Outputs: one-hot gnt[1:0].
  - Purely combinational; reusable for other shared resources.
- Top level holds the FSM, the latched request registers, the response register and the last_grant flop.

## Test plan
- Single write then read, port 0:
  - Write 0x12345678 to addr 8: p0_ack_o in cycle 2, err_o=0, mem_write_o high exactly 1 cycle.
  - Then read addr 8: p0_rdata_o=0x12345678.
- Contention:
  - Both ports request from reset, p0 write addr 0 and p1 read addr 0: p0 acked first, then p1 acked 3 cycles later with the data p0 wrote.
  - With both ports held requesting, grant order is 0,1,0,1.
- Errors:
  - p1 read at addr 6: p1_ack_o with err_o=1 and p1_rdata_o=0, no memory strobe.
  - p1 write at addr 29: no mem_write_o, err_o=1, and memory contents are unchanged on readback.
- Reset abort: p0 write 0xDEADBEEF to addr 4 with rst_i low in ACCESS: no ack, all outputs 0 next cycle, and addr 4 reads back its old value.
- Idle quietness: no requests for 10 cycles after reset: no ack and no strobe; mem_addr_o=0 throughout.
